// File: rtl/probe_frame_rx.sv
// Host-side decoder for the probe-trace UART link: 8N1 byte receiver plus 6-byte frame
// reassembly ({AA, probes, stamp[31:0] MSB first}) with line, sync and timestamp checks.
module probe_frame_rx #(
  parameter int CLKS_PER_BIT = 208,
  parameter int GAP_BITS     = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_valid,
  output logic [7:0]  frame_probes,
  output logic [31:0] frame_stamp,
  output logic        stamp_err,
  output logic        framing_err,
  output logic        sync_lost
);

  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  // Registered clear and registered pulse each cost one cycle, so firing at LIMIT-2 puts
  // sync_lost exactly GAP_LIMIT cycles after the byte_valid pulse.
  localparam logic [GAP_W-1:0] GAP_FIRE  = GAP_W'(GAP_LIMIT - 2);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic {
    FR_HUNT,
    FR_COLLECT
  } fr_state_t;

  // ---------------------------------------------------------------- synchroniser
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample its input from before the edge,
      // which is what makes this a two-stage chain rather than a single wire.
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------- byte receiver
  rx_state_t        rx_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_tick;
  logic             stop_bad;

  assign bit_tick = (bit_cnt == BIT_LAST);
  assign stop_bad = (rx_state == RX_STOP) && bit_tick && !rx_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state    <= RX_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              bit_idx  <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_tick) begin
            bit_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_tick) begin
            bit_cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
              rx_state   <= RX_IDLE;
            end else begin
              framing_err <= 1'b1;
              rx_state    <= RX_WAIT_HIGH;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          // A held-low break must not be mistaken for a stream of start bits.
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- frame assembly
  fr_state_t        fr_state;
  logic [2:0]       idx;
  logic [7:0]       probes_buf;
  logic [23:0]      stamp_buf;
  logic [GAP_W-1:0] gap_cnt;
  logic [31:0]      prev_stamp;
  logic             have_prev;
  logic [31:0]      new_stamp;
  logic [31:0]      stamp_delta;

  assign new_stamp   = {stamp_buf, byte_data};
  assign stamp_delta = new_stamp - prev_stamp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fr_state     <= FR_HUNT;
      idx          <= '0;
      probes_buf   <= '0;
      stamp_buf    <= '0;
      gap_cnt      <= '0;
      prev_stamp   <= '0;
      have_prev    <= 1'b0;
      frame_valid  <= 1'b0;
      frame_probes <= '0;
      frame_stamp  <= '0;
      stamp_err    <= 1'b0;
      sync_lost    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      stamp_err   <= 1'b0;
      sync_lost   <= 1'b0;
      if (fr_state == FR_COLLECT && stop_bad) begin
        sync_lost <= 1'b1;
        fr_state  <= FR_HUNT;
        gap_cnt   <= '0;
      end else if (byte_valid) begin
        gap_cnt <= '0;
        unique case (fr_state)
          FR_HUNT: begin
            if (byte_data == 8'hAA) begin
              fr_state <= FR_COLLECT;
              idx      <= '0;
            end
          end
          FR_COLLECT: begin
            idx <= idx + 1'b1;
            unique case (idx)
              3'd0:             probes_buf <= byte_data;
              3'd1, 3'd2, 3'd3: stamp_buf  <= {stamp_buf[15:0], byte_data};
              default: begin
                frame_valid  <= 1'b1;
                frame_probes <= probes_buf;
                frame_stamp  <= new_stamp;
                // Zero or "negative" modular step means the stamp failed to advance.
                stamp_err    <= have_prev && (stamp_delta == '0 || stamp_delta[31]);
                prev_stamp   <= new_stamp;
                have_prev    <= 1'b1;
                fr_state     <= FR_HUNT;
              end
            endcase
          end
          default: fr_state <= FR_HUNT;
        endcase
      end else if (fr_state == FR_COLLECT) begin
        if (gap_cnt == GAP_FIRE) begin
          sync_lost <= 1'b1;
          fr_state  <= FR_HUNT;
          gap_cnt   <= '0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
    end
  end

endmodule
